// File: rtl/lmem_wr_funnel_4to2.sv
// rtl/lmem_wr_funnel_4to2.sv - four write ports queued per port and drained onto two BRAM write ports
// Round-robin drain with same-address suppression on port B; bram_* outputs are registered.
module lmem_wr_funnel_4to2 #(
   parameter int DATA_WIDTH      = 18,
   parameter int ADDR_WIDTH      = 8,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we_0,
   input  logic                       we_1,
   input  logic                       we_2,
   input  logic                       we_3,
   input  logic [DATA_WIDTH-1:0]      data_0,
   input  logic [DATA_WIDTH-1:0]      data_1,
   input  logic [DATA_WIDTH-1:0]      data_2,
   input  logic [DATA_WIDTH-1:0]      data_3,
   input  logic [ADDR_WIDTH-1:0]      waddr_0,
   input  logic [ADDR_WIDTH-1:0]      waddr_1,
   input  logic [ADDR_WIDTH-1:0]      waddr_2,
   input  logic [ADDR_WIDTH-1:0]      waddr_3,
   output logic                       full_0,
   output logic                       full_1,
   output logic                       full_2,
   output logic                       full_3,
   output logic                       bram_we_a,
   output logic                       bram_we_b,
   output logic [ADDR_WIDTH-1:0]      bram_addr_a,
   output logic [ADDR_WIDTH-1:0]      bram_addr_b,
   output logic [DATA_WIDTH-1:0]      bram_data_a,
   output logic [DATA_WIDTH-1:0]      bram_data_b,
   output logic [FIFO_DEPTH_LOG2+2:0] pending,
   output logic                       idle,
   output logic                       overflow
);

   localparam int D  = 2**FIFO_DEPTH_LOG2;
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = FIFO_DEPTH_LOG2 + 1;
   localparam int PW = FIFO_DEPTH_LOG2 + 3;

   logic [EW-1:0]              mem  [4][D];
   logic [FIFO_DEPTH_LOG2-1:0] wp   [4];
   logic [FIFO_DEPTH_LOG2-1:0] rp   [4];
   logic [CW-1:0]              cnt  [4];
   logic [EW-1:0]              din  [4];
   logic [EW-1:0]              head [4];
   logic [3:0]                 we_v, full_v, push, pop;
   logic [1:0]                 rr, rr_next, sel_a, sel_b, idx;
   logic                       found_a, found_b, issue_b;
   logic [2:0]                 n_push;
   logic [1:0]                 n_pop;

   always_comb begin
      we_v   = {we_3, we_2, we_1, we_0};
      din[0] = {waddr_0, data_0};
      din[1] = {waddr_1, data_1};
      din[2] = {waddr_2, data_2};
      din[3] = {waddr_3, data_3};
      for (int i = 0; i < 4; i++) begin
         full_v[i] = (cnt[i] == CW'(D));
         head[i]   = mem[i][rp[i]];
      end
      // full comes from the registered count, so a same-cycle pop never frees a slot
      push = we_v & ~full_v;
   end

   always_comb begin
      found_a = 1'b0;
      found_b = 1'b0;
      sel_a   = rr;
      sel_b   = rr;
      idx     = rr;
      for (int k = 0; k < 4; k++) begin
         idx = rr + 2'(k);
         if (cnt[idx] != '0) begin
            if (!found_a) begin
               found_a = 1'b1;
               sel_a   = idx;
            end else if (!found_b) begin
               found_b = 1'b1;
               sel_b   = idx;
            end
         end
      end
      // B is held back when it would hit the same word as A in the same cycle
      issue_b = found_b &&
                (head[sel_b][EW-1 -: ADDR_WIDTH] != head[sel_a][EW-1 -: ADDR_WIDTH]);
      pop = '0;
      if (found_a) pop[sel_a] = 1'b1;
      if (issue_b) pop[sel_b] = 1'b1;
      rr_next = issue_b ? sel_b + 2'd1 : (found_a ? sel_a + 2'd1 : rr);
      n_push = '0;
      n_pop  = '0;
      for (int i = 0; i < 4; i++) n_push = n_push + 3'(push[i]);
      n_pop = 2'(found_a) + 2'(issue_b);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (push[i]) mem[i][wp[i]] <= din[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            wp[i]  <= '0;
            rp[i]  <= '0;
            cnt[i] <= '0;
         end
         rr          <= '0;
         pending     <= '0;
         overflow    <= 1'b0;
         bram_we_a   <= 1'b0;
         bram_we_b   <= 1'b0;
         bram_addr_a <= '0;
         bram_addr_b <= '0;
         bram_data_a <= '0;
         bram_data_b <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (push[i]) wp[i] <= wp[i] + 1'b1;
            if (pop[i])  rp[i] <= rp[i] + 1'b1;
            if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
            else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - 1'b1;
         end
         rr        <= rr_next;
         pending   <= pending + PW'(n_push) - PW'(n_pop);
         overflow  <= overflow | (|(we_v & full_v));
         bram_we_a <= found_a;
         bram_we_b <= issue_b;
         if (found_a) begin
            bram_addr_a <= head[sel_a][EW-1 -: ADDR_WIDTH];
            bram_data_a <= head[sel_a][DATA_WIDTH-1:0];
         end
         if (issue_b) begin
            bram_addr_b <= head[sel_b][EW-1 -: ADDR_WIDTH];
            bram_data_b <= head[sel_b][DATA_WIDTH-1:0];
         end
      end
   end

   assign full_0 = full_v[0];
   assign full_1 = full_v[1];
   assign full_2 = full_v[2];
   assign full_3 = full_v[3];
   assign idle   = (pending == '0) && !bram_we_a && !bram_we_b;

endmodule

// File: tb/tb_lmem_wr_funnel_4to2.sv
// tb/tb_lmem_wr_funnel_4to2.sv - directed self-checking bench for lmem_wr_funnel_4to2
module tb_lmem_wr_funnel_4to2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  we_r = '0;
   logic [17:0] data_r [4];
   logic [7:0]  addr_r [4];
   logic [3:0]  full_w;
   logic        bram_we_a, bram_we_b, idle, overflow;
   logic [7:0]  bram_addr_a, bram_addr_b;
   logic [17:0] bram_data_a, bram_data_b;
   logic [4:0]  pending;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lmem_wr_funnel_4to2 #(.DATA_WIDTH(18), .ADDR_WIDTH(8), .FIFO_DEPTH_LOG2(2)) dut (
      .clk(clk), .rst(rst),
      .we_0(we_r[0]), .we_1(we_r[1]), .we_2(we_r[2]), .we_3(we_r[3]),
      .data_0(data_r[0]), .data_1(data_r[1]), .data_2(data_r[2]), .data_3(data_r[3]),
      .waddr_0(addr_r[0]), .waddr_1(addr_r[1]), .waddr_2(addr_r[2]), .waddr_3(addr_r[3]),
      .full_0(full_w[0]), .full_1(full_w[1]), .full_2(full_w[2]), .full_3(full_w[3]),
      .bram_we_a(bram_we_a), .bram_we_b(bram_we_b),
      .bram_addr_a(bram_addr_a), .bram_addr_b(bram_addr_b),
      .bram_data_a(bram_data_a), .bram_data_b(bram_data_b),
      .pending(pending), .idle(idle), .overflow(overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      we_r = '0;
      rst  = 1'b1;
      tick();
      rst  = 1'b0;
   endtask

   // Saturation pattern: from empty, all four ports fill to 3,3,4,4 after six edges,
   // then ports {0,1} and {2,3} alternate between accepting and being full.
   function automatic bit accepted(int p, int c);
      if (c < 1 || c > 20) return 1'b0;
      if (c <= 6) return 1'b1;
      return (p < 2) ? (c % 2 == 1) : (c % 2 == 0);
   endfunction

   task automatic test_reset();
      do_reset();
      vectors++;
      if (bram_we_a !== 1'b0 || bram_we_b !== 1'b0 || bram_addr_a !== 8'h00 || bram_data_a !== 18'h0 ||
          pending !== 5'd0 || idle !== 1'b1 || overflow !== 1'b0 || full_w !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_state: we_a=%b we_b=%b addr_a=%h data_a=%h pending=%0d idle=%b ovf=%b full=%b, want all zero, idle=1",
                  bram_we_a, bram_we_b, bram_addr_a, bram_data_a, pending, idle, overflow, full_w);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      we_r[2] = 1'b1; addr_r[2] = 8'h15; data_r[2] = 18'h3A5;
      tick();
      we_r = '0;
      vectors++;
      if (bram_we_a !== 1'b0 || pending !== 5'd1) begin
         miscompares++;
         $display("FAIL single_n1: we_a=%b pending=%0d, want 0 and 1", bram_we_a, pending);
      end
      tick();
      vectors++;
      if (bram_we_a !== 1'b1 || bram_addr_a !== 8'h15 || bram_data_a !== 18'h3A5 || bram_we_b !== 1'b0 || idle !== 1'b0) begin
         miscompares++;
         $display("FAIL single_n2: we_a=%b addr=%h data=%h we_b=%b idle=%b, want 1 15 3a5 0 0",
                  bram_we_a, bram_addr_a, bram_data_a, bram_we_b, idle);
      end
      tick();
      vectors++;
      if (idle !== 1'b1 || bram_we_a !== 1'b0) begin
         miscompares++;
         $display("FAIL single_n3: idle=%b we_a=%b, want 1 0", idle, bram_we_a);
      end
   endtask

   task automatic test_four_way();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         we_r[i] = 1'b1; addr_r[i] = 8'(8'h10 + i); data_r[i] = 18'(18'h100 + i);
      end
      tick();
      we_r = '0;
      vectors++;
      if (pending !== 5'd4 || bram_we_a !== 1'b0) begin
         miscompares++;
         $display("FAIL four_pending4: pending=%0d we_a=%b, want 4 0", pending, bram_we_a);
      end
      tick();
      vectors++;
      if (bram_we_a !== 1'b1 || bram_we_b !== 1'b1 || bram_addr_a !== 8'h10 || bram_addr_b !== 8'h11 ||
          bram_data_b !== 18'h101 || pending !== 5'd2) begin
         miscompares++;
         $display("FAIL four_first: a=%b/%h b=%b/%h/%h pending=%0d, want 1/10 1/11/101 2",
                  bram_we_a, bram_addr_a, bram_we_b, bram_addr_b, bram_data_b, pending);
      end
      tick();
      vectors++;
      if (bram_we_a !== 1'b1 || bram_we_b !== 1'b1 || bram_addr_a !== 8'h12 || bram_addr_b !== 8'h13 || pending !== 5'd0) begin
         miscompares++;
         $display("FAIL four_second: a=%b/%h b=%b/%h pending=%0d, want 1/12 1/13 0",
                  bram_we_a, bram_addr_a, bram_we_b, bram_addr_b, pending);
      end
      tick();
      vectors++;
      if (bram_we_a !== 1'b0 || bram_we_b !== 1'b0 || idle !== 1'b1) begin
         miscompares++;
         $display("FAIL four_drained: we_a=%b we_b=%b idle=%b, want 0 0 1", bram_we_a, bram_we_b, idle);
      end
      // rr must be back at 0: port 0 wins A over port 3
      we_r[0] = 1'b1; addr_r[0] = 8'h30; we_r[3] = 1'b1; addr_r[3] = 8'h33;
      tick();
      we_r = '0;
      tick();
      vectors++;
      if (bram_addr_a !== 8'h30 || bram_addr_b !== 8'h33 || bram_we_b !== 1'b1) begin
         miscompares++;
         $display("FAIL four_rr_wrap: addr_a=%h addr_b=%h we_b=%b, want 30 33 1", bram_addr_a, bram_addr_b, bram_we_b);
      end
      tick();
   endtask

   task automatic test_conflict();
      do_reset();
      we_r[0] = 1'b1; addr_r[0] = 8'h40; data_r[0] = 18'h001;
      we_r[1] = 1'b1; addr_r[1] = 8'h40; data_r[1] = 18'h002;
      tick();
      we_r = '0;
      tick();
      vectors++;
      if (bram_we_a !== 1'b1 || bram_addr_a !== 8'h40 || bram_data_a !== 18'h001 || bram_we_b !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_k: a=%b/%h/%h we_b=%b, want 1/40/001 0", bram_we_a, bram_addr_a, bram_data_a, bram_we_b);
      end
      tick();
      vectors++;
      if (bram_we_a !== 1'b1 || bram_addr_a !== 8'h40 || bram_data_a !== 18'h002 || bram_we_b !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_k1: a=%b/%h/%h we_b=%b, want 1/40/002 0", bram_we_a, bram_addr_a, bram_data_a, bram_we_b);
      end
      tick();
   endtask

   task automatic test_saturate();
      int exp_next [4];
      int issued = 0;
      do_reset();
      for (int p = 0; p < 4; p++) exp_next[p] = 1;
      for (int c = 1; c <= 40; c++) begin
         for (int p = 0; p < 4; p++) begin
            we_r[p]   = (c <= 20);
            addr_r[p] = {2'(p), 6'(c)};
            data_r[p] = {2'(p), 8'h00, 8'(c)};
         end
         tick();
         if (c == 6) begin
            vectors++;
            if (full_w !== 4'b1100 || pending !== 5'd14 || overflow !== 1'b0) begin
               miscompares++;
               $display("FAIL sat_fill: full=%b pending=%0d ovf=%b, want 1100 14 0", full_w, pending, overflow);
            end
         end
         if (c == 7) begin
            vectors++;
            if (overflow !== 1'b1 || full_w !== 4'b0011) begin
               miscompares++;
               $display("FAIL sat_overflow: ovf=%b full=%b, want 1 0011", overflow, full_w);
            end
         end
         for (int s = 0; s < 2; s++) begin
            logic        w;
            logic [17:0] d;
            int          p;
            w = (s == 0) ? bram_we_a : bram_we_b;
            d = (s == 0) ? bram_data_a : bram_data_b;
            if (w) begin
               p = int'(d[17:16]);
               while (exp_next[p] <= 20 && !accepted(p, exp_next[p])) exp_next[p]++;
               vectors++;
               if (int'(d[7:0]) != exp_next[p]) begin
                  miscompares++;
                  $display("FAIL sat_order: port %0d issued seq %0d, want %0d", p, d[7:0], exp_next[p]);
               end
               exp_next[p]++;
               issued++;
            end
         end
      end
      we_r = '0;
      vectors++;
      if (issued != 52 || pending !== 5'd0 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_total: issued=%0d pending=%0d ovf=%b, want 52 0 1", issued, pending, overflow);
      end
   endtask

   task automatic test_reset_mid_drain();
      bit leaked = 1'b0;
      for (int i = 0; i < 4; i++) begin
         we_r[i] = 1'b1; addr_r[i] = 8'(8'h50 + i); data_r[i] = 18'(18'h050 + i);
      end
      tick();
      we_r = '0;
      we_r[0] = 1'b1; addr_r[0] = 8'h58;
      we_r[1] = 1'b1; addr_r[1] = 8'h59;
      tick();
      we_r = '0;
      vectors++;
      if (pending !== 5'd4) begin
         miscompares++;
         $display("FAIL rst_mid_pending: pending=%0d, want 4", pending);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (bram_we_a !== 1'b0 || bram_we_b !== 1'b0 || pending !== 5'd0 || full_w !== 4'h0 ||
          overflow !== 1'b0 || idle !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_state: we_a=%b we_b=%b pending=%0d full=%b ovf=%b idle=%b, want 0 0 0 0000 0 1",
                  bram_we_a, bram_we_b, pending, full_w, overflow, idle);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bram_we_a || bram_we_b) leaked = 1'b1;
      end
      vectors++;
      if (leaked) begin
         miscompares++;
         $display("FAIL rst_mid_leak: pre-reset write issued after reset, want none");
      end
   endtask

   task automatic test_fairness();
      do_reset();
      for (int j = 0; j < 10; j++) begin
         we_r[0] = 1'b1; addr_r[0] = 8'(8'h80 + j); data_r[0] = 18'(j);
         we_r[3] = 1'b1; addr_r[3] = 8'(8'hC0 + j); data_r[3] = 18'(18'h200 + j);
         tick();
         if (j >= 1) begin
            vectors++;
            if (bram_we_a !== 1'b1 || bram_we_b !== 1'b1 ||
                bram_addr_a !== 8'(8'h80 + j - 1) || bram_addr_b !== 8'(8'hC0 + j - 1)) begin
               miscompares++;
               $display("FAIL fair_%0d: a=%b/%h b=%b/%h, want 1/%h 1/%h", j, bram_we_a, bram_addr_a,
                        bram_we_b, bram_addr_b, 8'(8'h80 + j - 1), 8'(8'hC0 + j - 1));
            end
         end
      end
      we_r = '0;
      tick();
      vectors++;
      if (bram_addr_a !== 8'h89 || bram_addr_b !== 8'hC9 || pending !== 5'd0) begin
         miscompares++;
         $display("FAIL fair_last: addr_a=%h addr_b=%h pending=%0d, want 89 c9 0", bram_addr_a, bram_addr_b, pending);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         data_r[i] = '0;
         addr_r[i] = '0;
      end
      #1;
      test_reset();
      test_single_write();
      test_four_way();
      test_conflict();
      test_saturate();
      test_reset_mid_drain();
      test_fairness();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
